// File: rtl/lift_motion_ctrl.sv
// Lift car motion/door sequencer: steps the car one floor per MOVE_TICKS timebase
// ticks toward a single accepted target, then holds the door open for DOOR_TICKS.
module lift_motion_ctrl #(
    parameter int FLOORS     = 8,
    parameter int FLOOR_W    = 3,
    parameter int MOVE_TICKS = 10,
    parameter int DOOR_TICKS = 15
) (
    input  logic               clk_100MHz,
    input  logic               rst,
    input  logic               clk_200ms,
    input  logic               req_valid,
    input  logic [FLOOR_W-1:0] req_floor,
    output logic               req_ready,
    output logic               req_err,
    input  logic               door_hold,
    output logic [FLOOR_W-1:0] cur_floor,
    output logic [1:0]         dir,
    output logic               door_open,
    output logic               arrived
);

    localparam int MAX_TICKS = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);

    localparam logic [CNT_W-1:0]   MOVE_LAST = CNT_W'(MOVE_TICKS - 1);
    localparam logic [CNT_W-1:0]   DOOR_LAST = CNT_W'(DOOR_TICKS - 1);
    localparam logic [FLOOR_W:0]   FLOOR_LIM = (FLOOR_W + 1)'(FLOORS);
    localparam logic [FLOOR_W-1:0] FLOOR_TOP = FLOOR_W'(FLOORS - 1);

    localparam logic [1:0] DIR_STOP = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MOVE_UP,
        ST_MOVE_DOWN,
        ST_DOOR_OPEN
    } state_t;

    // Timebase synchroniser and edge detector
    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       edge_q, edge_d;
    logic [1:0] settle_q, settle_d;
    logic       armed_q, armed_d;
    logic       tick;

    // Sequencer state and registered outputs
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FLOOR_W-1:0] target_q, target_d;
    logic [FLOOR_W-1:0] cur_floor_q, cur_floor_d;
    logic [1:0]         dir_q, dir_d;
    logic               door_open_q, door_open_d;
    logic               arrived_q, arrived_d;
    logic               req_err_q, req_err_d;
    logic               req_ready_q, req_ready_d;

    logic               req_fire;
    logic [FLOOR_W-1:0] floor_up;
    logic [FLOOR_W-1:0] floor_down;

    // A tick is only trusted once the synchroniser holds real samples and the
    // input has been seen low, so a level already high at reset release is ignored.
    always_comb begin
        sync1_d  = clk_200ms;
        sync2_d  = sync1_q;
        edge_d   = sync2_q;
        settle_d = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
        armed_d  = armed_q | ((settle_q == 2'd2) & ~sync2_q);
        tick     = sync2_q & ~edge_q & armed_q;
    end

    assign req_fire   = req_valid & req_ready_q;
    assign floor_up   = (cur_floor_q == FLOOR_TOP) ? cur_floor_q : cur_floor_q + 1'b1;
    assign floor_down = (cur_floor_q == '0) ? cur_floor_q : cur_floor_q - 1'b1;

    always_comb begin
        // NOTE: every variable gets a default here so no path can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        target_d    = target_q;
        cur_floor_d = cur_floor_q;
        arrived_d   = 1'b0;
        req_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_fire) begin
                    cnt_d = '0;
                    if ({1'b0, req_floor} >= FLOOR_LIM) begin
                        req_err_d = 1'b1;
                    end else if (req_floor == cur_floor_q) begin
                        state_d   = ST_DOOR_OPEN;
                        arrived_d = 1'b1;
                    end else if (req_floor > cur_floor_q) begin
                        target_d = req_floor;
                        state_d  = ST_MOVE_UP;
                    end else begin
                        target_d = req_floor;
                        state_d  = ST_MOVE_DOWN;
                    end
                end
            end

            ST_MOVE_UP: begin
                if (tick) begin
                    if (cnt_q == MOVE_LAST) begin
                        cnt_d       = '0;
                        cur_floor_d = floor_up;
                        if (floor_up == target_q) begin
                            state_d   = ST_DOOR_OPEN;
                            arrived_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            ST_MOVE_DOWN: begin
                if (tick) begin
                    if (cnt_q == MOVE_LAST) begin
                        cnt_d       = '0;
                        cur_floor_d = floor_down;
                        if (floor_down == target_q) begin
                            state_d   = ST_DOOR_OPEN;
                            arrived_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            ST_DOOR_OPEN: begin
                // Holding the door beats a same-cycle tick, so it can never close while held.
                if (door_hold) begin
                    cnt_d = '0;
                end else if (tick) begin
                    if (cnt_q == DOOR_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Status outputs are decoded from the next state so they register with it.
        req_ready_d = (state_d == ST_IDLE);
        door_open_d = (state_d == ST_DOOR_OPEN);
        case (state_d)
            ST_MOVE_UP:   dir_d = DIR_UP;
            ST_MOVE_DOWN: dir_d = DIR_DOWN;
            default:      dir_d = DIR_STOP;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            edge_q      <= 1'b0;
            settle_q    <= 2'd0;
            armed_q     <= 1'b0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            target_q    <= '0;
            cur_floor_q <= '0;
            dir_q       <= DIR_STOP;
            door_open_q <= 1'b0;
            arrived_q   <= 1'b0;
            req_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            edge_q      <= edge_d;
            settle_q    <= settle_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            target_q    <= target_d;
            cur_floor_q <= cur_floor_d;
            dir_q       <= dir_d;
            door_open_q <= door_open_d;
            arrived_q   <= arrived_d;
            req_err_q   <= req_err_d;
            req_ready_q <= req_ready_d;
        end
    end

    assign req_ready = req_ready_q;
    assign req_err   = req_err_q;
    assign cur_floor = cur_floor_q;
    assign dir       = dir_q;
    assign door_open = door_open_q;
    assign arrived   = arrived_q;

endmodule

// File: tb/tb_lift_motion_ctrl.sv
// Directed bench for lift_motion_ctrl: short tick counts, clk_200ms driven as a
// 20-cycle square wave, expectations worked out by hand from the tick timing.
module tb_lift_motion_ctrl;

    // 4-bit floor field so out-of-range floors 8..15 can be requested.
    localparam int FLOORS     = 8;
    localparam int FLOOR_W    = 4;
    localparam int MOVE_TICKS = 2;
    localparam int DOOR_TICKS = 3;
    localparam int TICK_CYC   = 20;

    logic               clk_100MHz = 1'b0;
    logic               rst;
    logic               clk_200ms;
    logic               req_valid;
    logic [FLOOR_W-1:0] req_floor;
    logic               req_ready;
    logic               req_err;
    logic               door_hold;
    logic [FLOOR_W-1:0] cur_floor;
    logic [1:0]         dir;
    logic               door_open;
    logic               arrived;

    int tests   = 0;
    int fails   = 0;
    int ph      = 0;
    bit wave_en = 1'b0;
    int arr_cnt = 0;
    int err_cnt = 0;

    lift_motion_ctrl #(
        .FLOORS    (FLOORS),
        .FLOOR_W   (FLOOR_W),
        .MOVE_TICKS(MOVE_TICKS),
        .DOOR_TICKS(DOOR_TICKS)
    ) dut (
        .clk_100MHz(clk_100MHz),
        .rst       (rst),
        .clk_200ms (clk_200ms),
        .req_valid (req_valid),
        .req_floor (req_floor),
        .req_ready (req_ready),
        .req_err   (req_err),
        .door_hold (door_hold),
        .cur_floor (cur_floor),
        .dir       (dir),
        .door_open (door_open),
        .arrived   (arrived)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // One clock: sample just after the edge, then advance the slow wave.
    // A tick acts on the edge of the cycle that moves ph from 12 to 13.
    task automatic cyc();
        @(posedge clk_100MHz);
        #1;
        if (arrived === 1'b1) arr_cnt++;
        if (req_err === 1'b1) err_cnt++;
        if (wave_en) begin
            ph        = (ph + 1) % TICK_CYC;
            clk_200ms = (ph >= TICK_CYC / 2);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic request(input int f);
        req_valid = 1'b1;
        req_floor = FLOOR_W'(f);
        cyc();
        req_valid = 1'b0;
    endtask

    task automatic wait_floor(input logic [FLOOR_W-1:0] f, input int max_cyc, output int n);
        n = 0;
        while (cur_floor !== f && n < max_cyc) begin
            cyc();
            n++;
        end
    endtask

    task automatic wait_door_close(input int max_cyc, output int n);
        n = 0;
        while (door_open === 1'b1 && n < max_cyc) begin
            cyc();
            n++;
        end
    endtask

    initial begin
        int n;
        int arr0;
        int err0;
        int closed;

        rst       = 1'b1;
        clk_200ms = 1'b0;
        req_valid = 1'b0;
        req_floor = '0;
        door_hold = 1'b0;
        cycles(3);
        check("rst_floor", 32'(cur_floor), 0);
        check("rst_dir", 32'(dir), 0);
        check("rst_door", 32'(door_open), 0);
        check("rst_arrived", 32'(arrived), 0);
        check("rst_err", 32'(req_err), 0);
        check("rst_ready", 32'(req_ready), 1);
        rst     = 1'b0;
        ph      = 0;
        wave_en = 1'b1;
        cycles(5);

        // 1: up from 0 to 3, two ticks per floor, door open three ticks
        request(3);
        check("t1_dir_up", 32'(dir), 1);
        check("t1_ready_busy", 32'(req_ready), 0);
        wait_floor(1, 60, n);
        check("t1_floor1", 32'(cur_floor), 1);
        check("t1_first_gap", 32'(n > 20 && n <= 40), 1);
        check("t1_dir_at1", 32'(dir), 1);
        wait_floor(2, 60, n);
        check("t1_gap_2", 32'(n), 40);
        arr0 = arr_cnt;
        wait_floor(3, 60, n);
        check("t1_gap_3", 32'(n), 40);
        check("t1_arrived", 32'(arrived), 1);
        check("t1_dir_stop", 32'(dir), 0);
        check("t1_door_open", 32'(door_open), 1);
        wait_door_close(100, n);
        check("t1_door_time", 32'(n), 60);
        check("t1_ready_idle", 32'(req_ready), 1);
        check("t1_arrived_once", 32'(arr_cnt - arr0), 1);

        // 2: down from 3 to 0
        arr0 = arr_cnt;
        request(0);
        check("t2_dir_down", 32'(dir), 2);
        wait_floor(2, 60, n);
        check("t2_floor2", 32'(cur_floor), 2);
        wait_floor(1, 60, n);
        check("t2_gap_1", 32'(n), 40);
        wait_floor(0, 60, n);
        check("t2_gap_0", 32'(n), 40);
        check("t2_dir_stop", 32'(dir), 0);
        check("t2_arrived", 32'(arrived), 1);
        check("t2_door_open", 32'(door_open), 1);
        wait_door_close(100, n);
        check("t2_door_time", 32'(n), 60);
        check("t2_arrived_once", 32'(arr_cnt - arr0), 1);

        // 3: travel to 5, then request 5 while standing there
        request(5);
        wait_floor(5, 400, n);
        check("t3_reach5", 32'(cur_floor), 5);
        wait_door_close(100, n);
        check("t3_idle", 32'(req_ready), 1);
        arr0 = arr_cnt;
        request(5);
        check("t3_same_arrived", 32'(arrived), 1);
        check("t3_same_door", 32'(door_open), 1);
        check("t3_same_floor", 32'(cur_floor), 5);
        check("t3_same_dir", 32'(dir), 0);
        check("t3_same_ready", 32'(req_ready), 0);
        wait_door_close(100, n);
        check("t3_door_time", 32'(n > 40 && n <= 60), 1);
        check("t3_arrived_once", 32'(arr_cnt - arr0), 1);

        // 4: out-of-range floors 9 and 8 are dropped with an error pulse
        err0 = err_cnt;
        request(9);
        check("t4_err9", 32'(req_err), 1);
        check("t4_ready", 32'(req_ready), 1);
        check("t4_floor", 32'(cur_floor), 5);
        check("t4_dir", 32'(dir), 0);
        check("t4_door", 32'(door_open), 0);
        cyc();
        check("t4_err_pulse", 32'(req_err), 0);
        request(8);
        check("t4_err8", 32'(req_err), 1);
        cyc();
        check("t4_err_count", 32'(err_cnt - err0), 2);

        // 5: door held for ten ticks, then closes exactly three ticks after release
        request(5);
        door_hold = 1'b1;
        closed = 0;
        for (int i = 0; i < 10 * TICK_CYC; i++) begin
            cyc();
            if (door_open !== 1'b1) closed++;
        end
        check("t5_held_open", 32'(closed), 0);
        n = 0;
        while (ph != 13 && n < 2 * TICK_CYC) begin
            cyc();
            n++;
        end
        door_hold = 1'b0;
        wait_door_close(100, n);
        check("t5_release_time", 32'(n), 60);
        check("t5_ready", 32'(req_ready), 1);

        // 6a: timebase high at reset release must not produce a tick
        rst       = 1'b1;
        wave_en   = 1'b0;
        clk_200ms = 1'b1;
        cycles(3);
        check("t6_rst_floor", 32'(cur_floor), 0);
        rst = 1'b0;
        request(1);
        check("t6_dir_up", 32'(dir), 1);
        cycles(10);
        ph        = 0;
        clk_200ms = 1'b0;
        wave_en   = 1'b1;
        wait_floor(1, 60, n);
        check("t6_no_early_tick", 32'(n), 33);
        check("t6_arrived", 32'(arrived), 1);
        wait_door_close(100, n);
        check("t6_door_time", 32'(n), 60);

        // 6b: asynchronous reset in the middle of a move
        request(7);
        cycles(50);
        check("t6_moving", 32'(dir), 1);
        check("t6_busy", 32'(req_ready), 0);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_floor", 32'(cur_floor), 0);
        check("t6_async_dir", 32'(dir), 0);
        check("t6_async_ready", 32'(req_ready), 1);
        check("t6_async_door", 32'(door_open), 0);
        cycles(2);
        rst = 1'b0;
        cycles(3);
        check("t6_post_floor", 32'(cur_floor), 0);
        check("t6_post_ready", 32'(req_ready), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
